// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and the counter-width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } state_e;

  // Bits needed to hold values 0..value-1 (at least one bit).
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// W-bit adder/subtractor with carry-out. With sub=1 it computes x - y and
// cout=1 means "no borrow", i.e. x >= y.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, x} + {1'b0, y ^ {W{sub}}} + {{W{1'b0}}, sub};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Every operation takes XLEN+2 cycles: one PREP, XLEN RUN iterations, one FIX.
// Multiply is shift-add on magnitudes, divide is restoring division; both use
// the single shared add/sub unit. Signs are applied once, in FIX.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = clog2(XLEN);

  state_e state, state_next;

  // Operation context captured at launch.
  op_e             op_reg;
  logic            neg_res;   // negate product / quotient
  logic            neg_rem;   // negate remainder (dividend sign)
  logic [CW-1:0]   count;

  // Shared working registers:
  //   multiply: acc = running upper product, shift = multiplier / lower product
  //   divide:   acc = partial remainder,     shift = dividend / quotient
  //   opnd holds the multiplicand or the divisor magnitude.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] shift;
  logic [XLEN-1:0] opnd;

  logic            is_div;
  logic            in_signed;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [XLEN:0]   add_x, add_y, add_sum;
  logic            add_sub, add_cout;
  logic [XLEN:0]   mul_step;
  logic [XLEN-1:0] div_rem;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign is_div    = op_reg[1];
  assign in_signed = ~op[0];
  assign a_mag     = (in_signed && a[XLEN-1]) ? -a : a;
  assign b_mag     = (in_signed && b[XLEN-1]) ? -b : b;

  // Operand selection for the shared adder: accumulate for multiply,
  // trial subtract of the divisor from the shifted remainder for divide.
  always_comb begin
    add_x   = {1'b0, acc};
    add_y   = {1'b0, opnd};
    add_sub = 1'b0;
    if (is_div) begin
      add_x   = {acc, shift[XLEN-1]};
      add_sub = 1'b1;
    end
  end

  muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign mul_step = shift[0] ? add_sum : {1'b0, acc};
  assign div_rem  = add_cout ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];

  assign prod     = {acc, shift};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -shift : shift;
  assign rem_fix  = neg_rem ? -acc : acc;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; RUN leaves after the iteration where count is zero.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_PREP;
      S_PREP:  state_next = S_RUN;
      S_RUN:   if (count == '0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, clear/load, and one iteration per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg  <= OP_MULT;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      count   <= '0;
      acc     <= '0;
      shift   <= '0;
      opnd    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_reg  <= op_e'(op);
            neg_res <= in_signed & (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem <= in_signed & a[XLEN-1];
            if (op[1]) begin
              opnd  <= b_mag;
              shift <= a_mag;
            end else begin
              opnd  <= a_mag;
              shift <= b_mag;
            end
          end
        end
        S_PREP: begin
          acc   <= '0;
          count <= CW'(XLEN - 1);
        end
        S_RUN: begin
          count <= count - CW'(1);
          if (is_div) begin
            acc   <= div_rem;
            shift <= {shift[XLEN-2:0], add_cout};
          end else begin
            acc   <= mul_step[XLEN:1];
            shift <= {mul_step[0], shift[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: MTHI/MTLO land only in IDLE; FIX writes the signed-corrected result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= is_div ? rem_fix : prod_fix[2*XLEN-1:XLEN];
      lo <= is_div ? quo_fix : prod_fix[XLEN-1:0];
    end else if (state == S_IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  // Completion pulse for the cycle right after HI/LO are written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == S_FIX);
  end

  assign busy = (state != S_IDLE);

endmodule
